// File: rtl/led_fade_sequencer.sv
// led_fade_sequencer: generates 4-bit duty levels for NCH LED channels that
// "breathe" (ramp up, hold high, ramp down, hold low).
// The internal 4-bit frame counter fcnt runs in lockstep with the downstream
// pwmGenerator counters. Duty values change only on the edge where fcnt wraps
// 15->0, so every PWM frame uses a single duty value.
module led_fade_sequencer #(
  parameter int NCH         = 8,
  parameter int STEP_FRAMES = 1024,
  parameter int HOLD_STEPS  = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic [NCH-1:0]   ch_mask,
  output logic [4*NCH-1:0] level_out,
  output logic             frame_start,
  output logic             busy,
  output logic [2:0]       state_out
);

  localparam int FW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(STEP_FRAMES - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_STEPS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_UP      = 3'd1,
    S_HOLD_HI = 3'd2,
    S_DOWN    = 3'd3,
    S_HOLD_LO = 3'd4
  } state_t;

  logic [3:0]       fcnt;
  logic [FW-1:0]    frame_cnt;
  logic [HW-1:0]    hold_cnt;
  logic [3:0]       level;
  state_t           state;

  state_t           state_d;
  logic [3:0]       level_d;
  logic [HW-1:0]    hold_d;
  logic [4*NCH-1:0] level_masked;

  logic frame_end;
  logic step_tick;

  assign frame_end = (fcnt == 4'hF);
  assign step_tick = frame_end && (frame_cnt == FRAME_LAST);

  // Free-running PWM frame position, frame-per-step counter and frame_start pulse.
  // frame_start is the registered copy of fcnt==15, so it is high exactly while
  // fcnt==0, but not in the first cycle after reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fcnt        <= 4'd0;
      frame_cnt   <= '0;
      frame_start <= 1'b0;
    end else begin
      fcnt        <= fcnt + 4'd1;
      frame_start <= frame_end;
      if (frame_end) begin
        if (frame_cnt == FRAME_LAST) frame_cnt <= '0;
        else                         frame_cnt <= frame_cnt + FW'(1);
      end
    end
  end

  // Next-state and level decisions; everything holds except on step_tick.
  always_comb begin
    state_d = state;
    level_d = level;
    hold_d  = hold_cnt;
    if (step_tick) begin
      case (state)
        S_IDLE: begin
          if (enable) state_d = S_UP;
        end
        S_UP: begin
          if (!enable) begin
            state_d = S_DOWN;
          end else if (level != 4'hF) begin
            level_d = level + 4'd1;
          end else begin
            state_d = S_HOLD_HI;
            hold_d  = '0;
          end
        end
        S_HOLD_HI: begin
          if (!enable || hold_cnt == HOLD_LAST) state_d = S_DOWN;
          else                                  hold_d  = hold_cnt + HW'(1);
        end
        S_DOWN: begin
          if (level != 4'h0) begin
            level_d = level - 4'd1;
          end else if (enable) begin
            state_d = S_HOLD_LO;
            hold_d  = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_HOLD_LO: begin
          if (!enable)                   state_d = S_IDLE;
          else if (hold_cnt == HOLD_LAST) state_d = S_UP;
          else                           hold_d  = hold_cnt + HW'(1);
        end
        default: begin
          state_d = S_IDLE;
          level_d = 4'h0;
          hold_d  = '0;
        end
      endcase
    end
  end

  // Per-channel gating of the level that will be in force for the next frame.
  always_comb begin
    level_masked = '0;
    for (int i = 0; i < NCH; i++) begin
      level_masked[4*i +: 4] = ch_mask[i] ? level_d : 4'h0;
    end
  end

  // FSM state plus registered outputs; level_out and the mask sample only at the
  // 15->0 frame boundary so a new duty starts at counter 0 of the next frame.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      level     <= 4'h0;
      hold_cnt  <= '0;
      level_out <= '0;
      busy      <= 1'b0;
      state_out <= 3'd0;
    end else begin
      state     <= state_d;
      level     <= level_d;
      hold_cnt  <= hold_d;
      busy      <= (state_d != S_IDLE);
      state_out <= state_d;
      if (frame_end) level_out <= level_masked;
    end
  end

endmodule
